// File: rtl/serial_pattern_gen_if.sv
// Load channel for serial_pattern_gen: pattern word, bit order and valid/ready handshake.
interface serial_pattern_gen_if #(
    parameter int WIDTH = 8
);
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_data;
    logic             msb_first;

    modport master (
        output load_valid,
        output load_data,
        output msb_first,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  load_data,
        input  msb_first,
        output load_ready
    );
endinterface

// File: rtl/serial_pattern_gen.sv
// Parallel-to-serial pattern source for the 10110 detector: shifts a loaded word out
// MSB- or LSB-first, DIV clocks per bit, optionally repeating it endlessly.
module serial_pattern_gen #(
    parameter int WIDTH = 8,
    parameter int DIV   = 1
) (
    input  logic                     fclk,
    input  logic                     rst_n,
    serial_pattern_gen_if.slave      load_if,
    input  logic                     repeat_en,
    output logic                     val,
    output logic                     bit_strobe,
    output logic [$clog2(WIDTH)-1:0] bit_index,
    output logic                     busy,
    output logic                     done
);
    localparam int IDX_W = $clog2(WIDTH);
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t             state_reg,  state_next;
    logic [WIDTH-1:0]   shift_reg,  shift_next;
    logic [WIDTH-1:0]   saved_reg,  saved_next;
    logic [CNT_W-1:0]   div_reg,    div_next;
    logic [IDX_W-1:0]   index_reg,  index_next;
    logic               val_reg,    val_next;
    logic               strobe_reg, strobe_next;
    logic               done_reg,   done_next;

    // Words are stored already in transmit order so that the shifter only ever
    // moves left and the bit order is captured once, at acceptance.
    logic [WIDTH-1:0] data_rev;
    logic [WIDTH-1:0] data_ordered;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_rev
            assign data_rev[gi] = load_if.load_data[WIDTH-1-gi];
        end
    endgenerate

    assign data_ordered = load_if.msb_first ? load_if.load_data : data_rev;

    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            shift_reg  <= '0;
            saved_reg  <= '0;
            div_reg    <= '0;
            index_reg  <= '0;
            val_reg    <= 1'b0;
            strobe_reg <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            shift_reg  <= shift_next;
            saved_reg  <= saved_next;
            div_reg    <= div_next;
            index_reg  <= index_next;
            val_reg    <= val_next;
            strobe_reg <= strobe_next;
            done_reg   <= done_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        shift_next  = shift_reg;
        saved_next  = saved_reg;
        div_next    = div_reg;
        index_next  = index_reg;
        val_next    = val_reg;
        strobe_next = 1'b0;
        done_next   = 1'b0;

        unique case (state_reg)
            ST_IDLE: begin
                val_next   = 1'b0;
                index_next = '0;
                div_next   = '0;
                if (load_if.load_valid) begin
                    state_next  = ST_SHIFT;
                    shift_next  = data_ordered;
                    saved_next  = data_ordered;
                    val_next    = data_ordered[WIDTH-1];
                    strobe_next = 1'b1;
                end
            end

            ST_SHIFT: begin
                if (div_reg != DIV_LAST) begin
                    div_next = div_reg + CNT_W'(1);
                end else if (index_reg != IDX_LAST) begin
                    div_next    = '0;
                    shift_next  = {shift_reg[WIDTH-2:0], 1'b0};
                    val_next    = shift_reg[WIDTH-2];
                    index_next  = index_reg + IDX_W'(1);
                    strobe_next = 1'b1;
                end else if (repeat_en) begin
                    // Seamless restart: bit 0 of the saved word follows the last bit directly.
                    div_next    = '0;
                    shift_next  = saved_reg;
                    val_next    = saved_reg[WIDTH-1];
                    index_next  = '0;
                    strobe_next = 1'b1;
                end else begin
                    state_next = ST_IDLE;
                    div_next   = '0;
                    val_next   = 1'b0;
                    index_next = '0;
                    done_next  = 1'b1;
                end
            end

            default: state_next = ST_IDLE;
        endcase
    end

    assign load_if.load_ready = (state_reg == ST_IDLE);
    assign busy               = (state_reg == ST_SHIFT);
    assign val                = val_reg;
    assign bit_strobe         = strobe_reg;
    assign bit_index          = index_reg;
    assign done               = done_reg;

endmodule

// File: tb/tb_serial_pattern_gen.sv
// Directed bench for serial_pattern_gen: one instance at DIV=1, one at DIV=3.
module tb_serial_pattern_gen;
    logic       fclk;
    logic       rst_n;
    logic       repeat_en;
    logic       repeat_en2;
    logic       val1, strobe1, busy1, done1;
    logic [2:0] index1;
    logic       val2, strobe2, busy2, done2;
    logic [2:0] index2;

    int n_cmp;
    int n_err;

    serial_pattern_gen_if #(.WIDTH(8)) lif1 ();
    serial_pattern_gen_if #(.WIDTH(8)) lif2 ();

    serial_pattern_gen #(.WIDTH(8), .DIV(1)) dut1 (
        .fclk       (fclk),
        .rst_n      (rst_n),
        .load_if    (lif1),
        .repeat_en  (repeat_en),
        .val        (val1),
        .bit_strobe (strobe1),
        .bit_index  (index1),
        .busy       (busy1),
        .done       (done1)
    );

    serial_pattern_gen #(.WIDTH(8), .DIV(3)) dut2 (
        .fclk       (fclk),
        .rst_n      (rst_n),
        .load_if    (lif2),
        .repeat_en  (repeat_en2),
        .val        (val2),
        .bit_strobe (strobe2),
        .bit_index  (index2),
        .busy       (busy2),
        .done       (done2)
    );

    initial fclk = 1'b0;
    always #5 fclk = ~fclk;

    task automatic tick();
        @(posedge fclk);
        #1;
    endtask

    task automatic load1(input logic [7:0] data, input logic msb);
        lif1.load_data  = data;
        lif1.msb_first  = msb;
        lif1.load_valid = 1'b1;
        tick();
        lif1.load_valid = 1'b0;
    endtask

    task automatic test_reset();
        n_cmp++; if ({val1, strobe1, busy1, done1, index1} !== 7'd0) begin
            n_err++; $display("FAIL reset_outs1 got=%b want=0000000", {val1, strobe1, busy1, done1, index1});
        end
        n_cmp++; if ({val2, strobe2, busy2, done2, index2} !== 7'd0) begin
            n_err++; $display("FAIL reset_outs2 got=%b want=0000000", {val2, strobe2, busy2, done2, index2});
        end
        n_cmp++; if (lif1.load_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_ready got=%b want=1", lif1.load_ready);
        end
        rst_n = 1'b1;
        tick();
        $display("test_reset done");
    endtask

    // Both bit orders of the test-plan words produce the stream 1,0,1,1,0,0,0,0.
    task automatic test_bit_order();
        logic [7:0] words [2];
        logic       orders[2];
        logic [7:0] exp;
        words[0] = 8'hB0; orders[0] = 1'b1;
        words[1] = 8'h0D; orders[1] = 1'b0;
        exp = 8'b1011_0000;
        repeat_en = 1'b0;
        for (int v = 0; v < 2; v++) begin
            load1(words[v], orders[v]);
            for (int k = 0; k < 8; k++) begin
                n_cmp++; if (val1 !== exp[7-k]) begin
                    n_err++; $display("FAIL order%0d_val k=%0d got=%b want=%b", v, k, val1, exp[7-k]);
                end
                n_cmp++; if (index1 !== 3'(k)) begin
                    n_err++; $display("FAIL order%0d_index got=%0d want=%0d", v, index1, k);
                end
                n_cmp++; if ({strobe1, busy1, lif1.load_ready, done1} !== 4'b1100) begin
                    n_err++; $display("FAIL order%0d_ctl k=%0d got=%b want=1100", v, k, {strobe1, busy1, lif1.load_ready, done1});
                end
                tick();
            end
            n_cmp++; if ({done1, lif1.load_ready, val1, busy1} !== 4'b1100) begin
                n_err++; $display("FAIL order%0d_done got=%b want=1100", v, {done1, lif1.load_ready, val1, busy1});
            end
            tick();
            n_cmp++; if (done1 !== 1'b0) begin
                n_err++; $display("FAIL order%0d_done_pulse got=%b want=0", v, done1);
            end
            $display("test_bit_order word=%h msb_first=%b done", words[v], orders[v]);
        end
    endtask

    task automatic test_repeat();
        logic [7:0] exp;
        exp = 8'b1011_0101;
        repeat_en = 1'b1;
        load1(8'hB5, 1'b1);
        for (int w = 0; w < 3; w++) begin
            for (int k = 0; k < 8; k++) begin
                n_cmp++; if (val1 !== exp[7-k]) begin
                    n_err++; $display("FAIL repeat_val w=%0d k=%0d got=%b want=%b", w, k, val1, exp[7-k]);
                end
                n_cmp++; if ({index1, strobe1, busy1, done1} !== {3'(k), 3'b110}) begin
                    n_err++; $display("FAIL repeat_ctl w=%0d k=%0d got=%b want=%b", w, k, {index1, strobe1, busy1, done1}, {3'(k), 3'b110});
                end
                if (w == 2 && k == 3) repeat_en = 1'b0;
                tick();
            end
        end
        n_cmp++; if ({done1, val1, busy1} !== 3'b100) begin
            n_err++; $display("FAIL repeat_end got=%b want=100", {done1, val1, busy1});
        end
        tick();
        $display("test_repeat done");
    endtask

    task automatic test_div3();
        logic [7:0] exp;
        exp = 8'hA5;
        lif2.load_data  = 8'hA5;
        lif2.msb_first  = 1'b1;
        lif2.load_valid = 1'b1;
        tick();
        lif2.load_valid = 1'b0;
        for (int c = 0; c < 24; c++) begin
            n_cmp++; if (val2 !== exp[7 - c/3]) begin
                n_err++; $display("FAIL div3_val c=%0d got=%b want=%b", c, val2, exp[7 - c/3]);
            end
            n_cmp++; if ({strobe2, index2, done2} !== {(c % 3 == 0), 3'(c/3), 1'b0}) begin
                n_err++; $display("FAIL div3_ctl c=%0d got=%b want=%b", c, {strobe2, index2, done2}, {(c % 3 == 0), 3'(c/3), 1'b0});
            end
            tick();
        end
        n_cmp++; if ({done2, lif2.load_ready, busy2} !== 3'b110) begin
            n_err++; $display("FAIL div3_done got=%b want=110", {done2, lif2.load_ready, busy2});
        end
        tick();
        $display("test_div3 done");
    endtask

    task automatic test_reset_mid();
        logic [7:0] exp;
        load1(8'hF0, 1'b1);
        repeat (4) tick();
        n_cmp++; if ({index1, val1} !== 4'b100_0) begin
            n_err++; $display("FAIL midreset_pre got=%b want=1000", {index1, val1});
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if ({val1, strobe1, busy1, done1, index1, lif1.load_ready} !== 8'b0000_0001) begin
            n_err++; $display("FAIL midreset_async got=%b want=00000001", {val1, strobe1, busy1, done1, index1, lif1.load_ready});
        end
        tick();
        rst_n = 1'b1;
        tick();
        exp = 8'h0F;
        load1(8'h0F, 1'b1);
        for (int k = 0; k < 8; k++) begin
            n_cmp++; if ({val1, index1} !== {exp[7-k], 3'(k)}) begin
                n_err++; $display("FAIL midreset_reload k=%0d got=%b want=%b", k, {val1, index1}, {exp[7-k], 3'(k)});
            end
            tick();
        end
        n_cmp++; if (done1 !== 1'b1) begin
            n_err++; $display("FAIL midreset_done got=%b want=1", done1);
        end
        tick();
        $display("test_reset_mid done");
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_a;
        logic [7:0] exp_b;
        exp_a = 8'b1011_0000;
        exp_b = 8'b0101_1100;  // 8'h3A sent LSB-first
        load1(8'hB0, 1'b1);
        lif1.load_data  = 8'h3A;
        lif1.msb_first  = 1'b0;
        lif1.load_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            n_cmp++; if ({val1, lif1.load_ready, index1} !== {exp_a[7-k], 1'b0, 3'(k)}) begin
                n_err++; $display("FAIL b2b_first k=%0d got=%b want=%b", k, {val1, lif1.load_ready, index1}, {exp_a[7-k], 1'b0, 3'(k)});
            end
            tick();
        end
        n_cmp++; if ({done1, lif1.load_ready, val1, busy1} !== 4'b1100) begin
            n_err++; $display("FAIL b2b_gap got=%b want=1100", {done1, lif1.load_ready, val1, busy1});
        end
        tick();
        lif1.load_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            n_cmp++; if ({val1, index1, busy1, strobe1} !== {exp_b[7-k], 3'(k), 2'b11}) begin
                n_err++; $display("FAIL b2b_second k=%0d got=%b want=%b", k, {val1, index1, busy1, strobe1}, {exp_b[7-k], 3'(k), 2'b11});
            end
            tick();
        end
        n_cmp++; if (done1 !== 1'b1) begin
            n_err++; $display("FAIL b2b_done got=%b want=1", done1);
        end
        tick();
        $display("test_back_to_back done");
    endtask

    initial begin
        n_cmp           = 0;
        n_err           = 0;
        rst_n           = 1'b0;
        repeat_en       = 1'b0;
        repeat_en2      = 1'b0;
        lif1.load_valid = 1'b0;
        lif1.load_data  = '0;
        lif1.msb_first  = 1'b0;
        lif2.load_valid = 1'b0;
        lif2.load_data  = '0;
        lif2.msb_first  = 1'b0;
        tick();
        tick();
        test_reset();
        test_bit_order();
        test_repeat();
        test_div3();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/serial_pattern_gen.md
# serial_pattern_gen

Parallel-to-serial bit-stream generator that drives the `val` input of the 10110 sequence detector (`mod2`). It accepts a WIDTH-bit pattern word, for example from board switches, over a valid/ready handshake. It shifts the word out one bit at a time, MSB- or LSB-first, with optional endless repetition, so detector behaviour can be exercised from a known stimulus source on the board.

## Interface

Parameters:
- `WIDTH`, 8: pattern word length in bits; must be ≥2.
- `DIV`, 1: `fclk` cycles per serial bit; must be ≥1. Must be 1 when `val` feeds `mod2` directly, because `mod2` samples every `fclk` edge.

Ports:
- `fclk`  input  1  system clock; all state changes on the rising edge.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `load_valid`  input  1  pattern word offered.
- `load_ready`  output  1  block can accept a word; high exactly in IDLE.
- `load_data`  input  WIDTH  pattern word.
- `msb_first`  input  1  bit order; sampled only at load acceptance.
- `repeat_en`  input  1  restart the same word after its last bit; sampled live.
- `val`  output  1  serial bit stream; registered.
- `bit_strobe`  output  1  high on the first `fclk` cycle of each new bit on `val`.
- `bit_index`  output  $clog2(WIDTH)  position of the current bit in transmit order, 0..WIDTH-1.
- `busy`  output  1  high in SHIFT.
- `done`  output  1  one-cycle pulse after the final bit of a non-repeated word.

## Operation

- States:
  - IDLE: `load_ready`=1, `val`=0.
  - SHIFT: transmitting.
- Reset (`rst_n`=0, at any time, including mid-word):
  - State goes to IDLE immediately.
  - `val`, `bit_strobe`, `done`, `busy` and `bit_index` are all 0.
  - The shift register, saved word and divider counter are cleared.
- IDLE → SHIFT on `load_valid && load_ready` at an edge. That edge:
  - copies `load_data` into the shift register and into a saved-word register;
  - latches `msb_first`;
  - drives `val` with bit 0 in transmit order (`load_data[WIDTH-1]` if `msb_first`, else `load_data[0]`);
  - sets `bit_strobe`=1, `bit_index`=0, and the divider counter to 0.
- In SHIFT:
  - The divider counts 0..DIV-1.
  - On the edge where the divider is DIV-1 and `bit_index` < WIDTH-1, the next bit is driven, `bit_index` increments, `bit_strobe`=1 and the divider returns to 0.
  - On all other edges, `bit_strobe`=0.
- End of word: the edge where the divider is DIV-1 and `bit_index` = WIDTH-1.
  - If `repeat_en`=1, the saved word is reloaded with the same bit order. Bit 0 is driven, `bit_index`=0, `bit_strobe`=1, and the block stays in SHIFT with no gap cycle.
  - If `repeat_en`=0, the block goes to IDLE with `val`=0 and `done`=1 for that one cycle.
- `load_valid` while in SHIFT is ignored (`load_ready`=0); the word is not queued.
- Clearing `repeat_en` mid-word lets the current word finish, then ends normally.
- `load_data` and `msb_first` changes after acceptance have no effect on the word in flight.

## Timing

- Load accepted at edge N: bit 0 is visible on `val` in cycle N+1 (registered, latency 1).
- Bit k occupies cycles N+1+k·DIV through N+(k+1)·DIV.
- A non-repeated word occupies WIDTH·DIV cycles. `done` is high in cycle N+1+WIDTH·DIV, the first IDLE cycle.
- `load_ready` is high during the `done` cycle, so a back-to-back load is accepted at that cycle's closing edge. The minimum gap is one cycle with `val`=0.
- Repeat mode: the period is exactly WIDTH·DIV cycles with no gap.
- With DIV=1, `bit_strobe` is constantly 1 throughout SHIFT.
- `busy` equals (state == SHIFT), registered alongside `val`.

## Test plan

- WIDTH=8, DIV=1, `msb_first`=1: load 8'b1011_0000 → `val`=1,0,1,1,0,0,0,0 in cycles N+1..N+8, `done`=1 in N+9, `load_ready`=1 from N+9. Feeding `mod2`, `flag`=1 exactly once, in cycle N+6.
- `msb_first`=0: load 8'h0D → `val`=1,0,1,1,0,0,0,0, with `bit_index` 0..7 alongside.
- `repeat_en`=1, load 8'b1011_0101 MSB-first → the stream repeats every 8 cycles with no gap. Dropping `repeat_en` during word 3 ends after word 3's eighth bit, then `done` pulses.
- DIV=3: load 8'hA5 MSB-first → each bit is held 3 cycles, `bit_strobe` pulses every 3rd cycle, and `done` comes 25 cycles after acceptance.
- Reset is asserted in SHIFT at `bit_index`=4. The next load then restarts at bit 0 with the new word.
- `load_valid`=1 with a different word during SHIFT → ignored; the original word completes unchanged. Holding `load_valid` high through the `done` cycle → the new word starts after exactly one 0 gap cycle.
